wash_coin_panel: RTL and testbench

WASH_COIN_PANEL -- requirements
Module: wash_coin_panel

---
 rtl/wash_coin_panel_pkg.sv | 21 ++
 rtl/wash_btn_debounce.sv | 34 +++
 rtl/wash_coin_panel.sv | 190 +++++++++++++++++++
 tb/tb_wash_coin_panel.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_coin_panel_pkg.sv
// wash_coin_panel_pkg: panel state encoding and coin-acceptor constants shared by
// the wash_coin_panel top and its bench.
package wash_coin_panel_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_START,
        S_RUNNING,
        S_DONE
    } state_t;

    localparam int              COIN_W    = 2;
    localparam logic [COIN_W-1:0] COIN_NONE = 2'd0;

    // A strobe carrying value 0 is noise from the acceptor, not a coin.
    function automatic logic coin_offered(input logic valid, input logic [COIN_W-1:0] val);
        return valid && (val != COIN_NONE);
    endfunction

endpackage

// File: rtl/wash_btn_debounce.sv
// wash_btn_debounce: emits a single-cycle press pulse once the raw button has been
// high for DEBOUNCE_CYCLES consecutive cycles; holding the button gives no repeats.
module wash_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int              CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: registers are assigned with <= so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            press <= 1'b0;
        end else begin
            press <= raw && (cnt_q == LAST);
            // Saturating at FULL is what suppresses repeat pulses while held.
            if (!raw) begin
                cnt_q <= '0;
            end else if (cnt_q != FULL) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wash_coin_panel.sv
// wash_coin_panel: coin/credit front panel for a washing controller.
// Define WASH_COIN_PANEL_REFUND_EN for refund strobes and cancel; otherwise change carries over.
module wash_coin_panel
    import wash_coin_panel_pkg::*;
#(
    parameter int PRICE           = 4,
    parameter int DOUBLE_PRICE    = 6,
    parameter int CREDIT_W        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BUZZ_CYCLES     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_val,
    input  logic                double_btn,
    input  logic                pause_btn,
    input  logic                cancel_btn,
    input  logic                wash_done,
    output logic                coin_in,
    output logic                double_wash,
    output logic                time_pause,
    output logic                coin_reject,
    output logic                refund_valid,
    output logic [CREDIT_W-1:0] refund_amt,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                buzzer
);

    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] DPRICE_C   = CREDIT_W'(DOUBLE_PRICE);
    localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam int                  BUZZ_W     = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
    localparam logic [BUZZ_W-1:0]   BUZZ_LAST  = BUZZ_W'(BUZZ_CYCLES - 1);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                double_sel_q, double_sel_d;
    logic                double_wash_q, double_wash_d;
    logic                pause_q, pause_d;
    logic [BUZZ_W-1:0]   buzz_q, buzz_d;
    logic                reject_q, reject_d;
    logic                cancel_refund_q, cancel_refund_d;
    logic [CREDIT_W-1:0] cancel_amt_q, cancel_amt_d;
    logic                wash_done_q;

    logic                double_press, pause_press, cancel_press, cancel_hit;
    logic                coin_ok, fits, done_rise;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W-1:0] required, leftover, carry_credit;

    wash_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_double_db (
        .clk(clk), .rst(rst), .raw(double_btn), .press(double_press));
    wash_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
        .clk(clk), .rst(rst), .raw(pause_btn), .press(pause_press));
    wash_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel_db (
        .clk(clk), .rst(rst), .raw(cancel_btn), .press(cancel_press));

    assign coin_ok   = coin_offered(coin_valid, coin_val);
    assign sum       = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_val);
    assign fits      = (sum <= CREDIT_MAX);
    assign required  = double_sel_q ? DPRICE_C : PRICE_C;
    assign leftover  = credit_q - required;
    assign done_rise = wash_done && !wash_done_q;

`ifdef WASH_COIN_PANEL_REFUND_EN
    assign cancel_hit   = cancel_press;
    assign carry_credit = '0;
    assign refund_valid = (state_q == S_START) || cancel_refund_q;
    assign refund_amt   = (state_q == S_START) ? leftover : cancel_amt_q;
`else
    // Without refunds the change stays on as credit for the next customer.
    logic unused_cancel;
    assign unused_cancel = cancel_press ^ cancel_refund_q ^ (^cancel_amt_q);
    assign cancel_hit    = 1'b0;
    assign carry_credit  = leftover;
    assign refund_valid  = 1'b0;
    assign refund_amt    = '0;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        double_sel_d    = double_sel_q;
        double_wash_d   = double_wash_q;
        pause_d         = pause_q;
        buzz_d          = buzz_q;
        reject_d        = 1'b0;
        cancel_refund_d = 1'b0;
        cancel_amt_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (double_press) double_sel_d = !double_sel_q;
                if (coin_ok) begin
                    if (fits) begin
                        credit_d = sum[CREDIT_W-1:0];
                        state_d  = S_CREDIT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            S_CREDIT: begin
                if (cancel_hit) begin
                    cancel_refund_d = 1'b1;
                    cancel_amt_d    = credit_q;
                    credit_d        = '0;
                    reject_d        = coin_ok;
                    state_d         = S_IDLE;
                end else if (credit_q >= required) begin
                    double_wash_d = double_sel_q;
                    reject_d      = coin_ok;
                    state_d       = S_START;
                end else begin
                    if (double_press) double_sel_d = !double_sel_q;
                    if (coin_ok) begin
                        if (fits) credit_d = sum[CREDIT_W-1:0];
                        else      reject_d = 1'b1;
                    end
                end
            end
            S_START: begin
                credit_d = carry_credit;
                reject_d = coin_ok;
                state_d  = S_RUNNING;
            end
            S_RUNNING: begin
                reject_d = coin_ok;
                if (pause_press) pause_d = !pause_q;
                if (done_rise) begin
                    pause_d = 1'b0;
                    buzz_d  = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                reject_d = coin_ok;
                if (buzz_q == BUZZ_LAST) begin
                    double_sel_d  = 1'b0;
                    double_wash_d = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    buzz_d = buzz_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The reject line is a pulse; back-to-back offers never merge into a level.
        reject_d = reject_d && !reject_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            credit_q        <= '0;
            double_sel_q    <= 1'b0;
            double_wash_q   <= 1'b0;
            pause_q         <= 1'b0;
            buzz_q          <= '0;
            reject_q        <= 1'b0;
            cancel_refund_q <= 1'b0;
            cancel_amt_q    <= '0;
            wash_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            double_sel_q    <= double_sel_d;
            double_wash_q   <= double_wash_d;
            pause_q         <= pause_d;
            buzz_q          <= buzz_d;
            reject_q        <= reject_d;
            cancel_refund_q <= cancel_refund_d;
            cancel_amt_q    <= cancel_amt_d;
            wash_done_q     <= wash_done;
        end
    end

    assign coin_in     = (state_q == S_START);
    assign busy        = (state_q == S_START) || (state_q == S_RUNNING) || (state_q == S_DONE);
    assign buzzer      = (state_q == S_DONE);
    assign credit      = credit_q;
    assign double_wash = double_wash_q;
    assign time_pause  = pause_q;
    assign coin_reject = reject_q;

endmodule

// File: tb/tb_wash_coin_panel.sv
// tb_wash_coin_panel: table-driven purchases plus hand-written corner sequences;
// START and refund events are checked against a scoreboard of expected results.
module tb_wash_coin_panel;

    localparam int PRICE = 4, DOUBLE_PRICE = 6, CREDIT_W = 4, DEB = 16, BUZZ = 8;
`ifdef WASH_COIN_PANEL_REFUND_EN
    localparam bit REFUND_EN = 1'b1;
`else
    localparam bit REFUND_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, coin_valid, double_btn, pause_btn, cancel_btn, wash_done;
    logic [1:0] coin_val;
    logic coin_in, double_wash, time_pause, coin_reject, refund_valid, busy, buzzer;
    logic [CREDIT_W-1:0] refund_amt, credit;

    // Second instance with price at full scale so the credit ceiling is reachable.
    logic ovf_coin_valid;
    logic [1:0] ovf_coin_val;
    logic ovf_coin_in, ovf_double_wash, ovf_time_pause, ovf_coin_reject, ovf_refund_valid;
    logic ovf_busy, ovf_buzzer;
    logic [CREDIT_W-1:0] ovf_refund_amt, ovf_credit;

    always #5 clk = ~clk;

    wash_coin_panel #(.PRICE(PRICE), .DOUBLE_PRICE(DOUBLE_PRICE), .CREDIT_W(CREDIT_W),
                      .DEBOUNCE_CYCLES(DEB), .BUZZ_CYCLES(BUZZ)) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
        .double_btn(double_btn), .pause_btn(pause_btn), .cancel_btn(cancel_btn),
        .wash_done(wash_done), .coin_in(coin_in), .double_wash(double_wash),
        .time_pause(time_pause), .coin_reject(coin_reject), .refund_valid(refund_valid),
        .refund_amt(refund_amt), .credit(credit), .busy(busy), .buzzer(buzzer));

    wash_coin_panel #(.PRICE(15), .DOUBLE_PRICE(15), .CREDIT_W(CREDIT_W),
                      .DEBOUNCE_CYCLES(DEB), .BUZZ_CYCLES(BUZZ)) dut_ovf (
        .clk(clk), .rst(rst), .coin_valid(ovf_coin_valid), .coin_val(ovf_coin_val),
        .double_btn(1'b0), .pause_btn(1'b0), .cancel_btn(1'b0), .wash_done(1'b0),
        .coin_in(ovf_coin_in), .double_wash(ovf_double_wash), .time_pause(ovf_time_pause),
        .coin_reject(ovf_coin_reject), .refund_valid(ovf_refund_valid),
        .refund_amt(ovf_refund_amt), .credit(ovf_credit), .busy(ovf_busy), .buzzer(ovf_buzzer));

    typedef struct {
        logic            dbl;
        int              n;
        logic [2:0][1:0] coins;      // coins[0] is inserted first
        int              exp_total;  // credit at START when no carried credit
        int              exp_refund;
    } vec_t;

    int   n_tests = 0, n_fail = 0;
    int   residue = 0;
    logic start_q[$];
    int   refund_q[$];
    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_coin(input logic [1:0] v);
        coin_valid = 1'b1; coin_val = v;
        tick();
        coin_valid = 1'b0; coin_val = 2'd0;
    endtask

    task automatic drive_ovf_coin(input logic [1:0] v);
        ovf_coin_valid = 1'b1; ovf_coin_val = v;
        tick();
        ovf_coin_valid = 1'b0; ovf_coin_val = 2'd0;
    endtask

    // 0 = double, 1 = pause, 2 = cancel; held long enough for exactly one press.
    task automatic press_btn(input int which);
        case (which)
            0: double_btn = 1'b1;
            1: pause_btn  = 1'b1;
            default: cancel_btn = 1'b1;
        endcase
        tick(DEB + 2);
        double_btn = 1'b0; pause_btn = 1'b0; cancel_btn = 1'b0;
        tick(2);
    endtask

    function automatic vec_t mk(input logic dbl, input int n, input logic [1:0] c0,
                                input logic [1:0] c1, input logic [1:0] c2,
                                input int tot, input int refund);
        vec_t v;
        v.dbl = dbl; v.n = n; v.coins = {c2, c1, c0};
        v.exp_total = tot; v.exp_refund = refund;
        return v;
    endfunction

    // Buys one wash; returns in the START cycle.
    task automatic run_vec(input vec_t v);
        int cred, req;
        req = v.dbl ? DOUBLE_PRICE : PRICE;
        if (v.dbl) press_btn(0);
        start_q.push_back(v.dbl);
        if (REFUND_EN) refund_q.push_back(v.exp_refund);
        cred = residue;
        for (int i = 0; i < v.n; i++) begin
            drive_coin(v.coins[i]);
            cred += int'(v.coins[i]);
            if (i < v.n - 1) check("credit_accum", credit, cred);
        end
        check("credit_total", credit, residue + v.exp_total);
        check("no_early_start", coin_in, 0);
        tick();
        check("start_coin_in", coin_in, 1);
        residue = REFUND_EN ? 0 : residue + v.exp_total - req;
    endtask

    task automatic finish_wash();
        int cnt;
        wash_done = 1'b1;
        tick();
        wash_done = 1'b0;
        check("done_pause_clear", time_pause, 0);
        cnt = 0;
        while (buzzer && cnt < 3 * BUZZ) begin
            cnt++;
            tick();
        end
        check("buzz_len", cnt, BUZZ);
        check("idle_after_done", busy, 0);
        check("double_clear", double_wash, 0);
        check("idle_credit", credit, residue);
    endtask

    // Scoreboard: every START and refund event must match the oldest expectation.
    logic prev_reject = 1'b0, prev_refund = 1'b0, prev_coin_in = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_reject = 1'b0; prev_refund = 1'b0; prev_coin_in = 1'b0;
        end else begin
            if (coin_in) begin
                if (start_q.size() == 0) check("unexpected_coin_in", coin_in, 0);
                else check("start_double_wash", double_wash, start_q.pop_front());
            end
            if (refund_valid) begin
                if (refund_q.size() == 0) check("unexpected_refund", refund_valid, 0);
                else check("refund_amt", refund_amt, refund_q.pop_front());
            end
            if (prev_reject)  check("reject_one_cycle", coin_reject, 0);
            if (prev_refund)  check("refund_one_cycle", refund_valid, 0);
            if (prev_coin_in) check("coin_in_one_cycle", coin_in, 0);
            prev_reject = coin_reject; prev_refund = refund_valid; prev_coin_in = coin_in;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(1'b0, 2, 2'd3, 2'd1, 2'd0, 4, 0);
        vecs[1] = mk(1'b1, 2, 2'd3, 2'd3, 2'd0, 6, 0);
        vecs[2] = mk(1'b1, 3, 2'd3, 2'd1, 2'd3, 7, 1);

        rst = 1'b1; coin_valid = 1'b0; coin_val = 2'd0; double_btn = 1'b0;
        pause_btn = 1'b0; cancel_btn = 1'b0; wash_done = 1'b0;
        ovf_coin_valid = 1'b0; ovf_coin_val = 2'd0;
        tick(3);
        rst = 1'b0;
        check("rst_credit", credit, 0);
        check("rst_busy", busy, 0);
        check("rst_outputs", {coin_in, double_wash, time_pause, coin_reject, refund_valid, buzzer}, 0);
        check("rst_refund_amt", refund_amt, 0);

        // Credit ceiling: 14 + 3 overflows, 14 + 1 lands exactly on the maximum.
        for (int i = 0; i < 4; i++) drive_ovf_coin(2'd3);
        drive_ovf_coin(2'd2);
        check("ovf_credit_14", ovf_credit, 14);
        drive_ovf_coin(2'd3);
        check("ovf_reject", ovf_coin_reject, 1);
        check("ovf_credit_kept", ovf_credit, 14);
        drive_ovf_coin(2'd1);
        check("ovf_credit_max", ovf_credit, 15);
        check("ovf_max_no_reject", ovf_coin_reject, 0);
        tick();
        check("ovf_start", ovf_coin_in, 1);

        // Cancel together with a coin: cancel wins when refunds exist, else it is ignored.
        drive_coin(2'd2);
        check("cancel_pre_credit", credit, 2);
        cancel_btn = 1'b1;
        tick(DEB);
        coin_valid = 1'b1; coin_val = 2'd2;
        if (REFUND_EN) refund_q.push_back(2);
        else start_q.push_back(1'b0);
        tick();
        coin_valid = 1'b0; coin_val = 2'd0; cancel_btn = 1'b0;
        check("cancel_refund_valid", refund_valid, REFUND_EN);
        check("cancel_refund_amt", refund_amt, REFUND_EN ? 2 : 0);
        check("cancel_coin_reject", coin_reject, REFUND_EN);
        check("cancel_credit", credit, REFUND_EN ? 0 : 4);
        tick();
        check("cancel_busy", busy, !REFUND_EN);
        if (busy) begin
            tick();
            finish_wash();
        end

        for (int i = 0; i < 3; i++) begin
            run_vec(vecs[i]);
            tick();
            check("running_double", double_wash, vecs[i].dbl);
            check("running_credit", credit, residue);
            finish_wash();
        end

        // wash_done level in IDLE and zero-valued coin strobes do nothing.
        wash_done = 1'b1;
        tick(5);
        check("idle_done_busy", busy, 0);
        check("idle_done_buzzer", buzzer, 0);
        wash_done = 1'b0;
        drive_coin(2'd0);
        check("zero_coin_credit", credit, residue);
        check("zero_coin_reject", coin_reject, 0);
        tick();

        // Pause debounce and button/coin handling while running.
        run_vec(mk(1'b0, 2, 2'd2, 2'd2, 2'd0, 4, 0));
        tick();
        pause_btn = 1'b1;
        tick(DEB - 1);
        check("pause_not_yet", time_pause, 0);
        tick(5);
        check("pause_after_hold", time_pause, 1);
        pause_btn = 1'b0;
        tick(2);
        press_btn(1);
        check("pause_second_press", time_pause, 0);
        drive_coin(2'd2);
        check("running_coin_reject", coin_reject, 1);
        check("running_coin_credit", credit, residue);
        press_btn(0);
        check("running_double_ignored", double_wash, 0);
        press_btn(2);
        check("running_cancel_ignored", busy, 1);
        press_btn(1);
        check("pause_third_press", time_pause, 1);
        finish_wash();

        // Reset mid-wash drops everything without a refund.
        run_vec(mk(1'b1, 2, 2'd3, 2'd3, 2'd0, 6, 0));
        tick();
        press_btn(1);
        check("pre_reset_pause", time_pause, 1);
        check("pre_reset_double", double_wash, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        residue = 0;
        check("reset_double", double_wash, 0);
        check("reset_pause", time_pause, 0);
        check("reset_busy", busy, 0);
        check("reset_credit", credit, 0);
        check("reset_refund", refund_valid, 0);
        drive_coin(2'd3);
        check("post_reset_credit", credit, 3);
        tick(2);

        check("start_queue_empty", start_q.size(), 0);
        check("refund_queue_empty", refund_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
